// File: rtl/alu_sweep_pkg.sv
// Shared definitions for the ALU sweep harness: op encodings, FSM state type and operand ROM contents.
// Used by alu_sweep_pipe (optional ALU_SWEEP_OVF_EN overflow output) and alu_nbits_core.
package alu_sweep_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  // Returned wide; callers truncate to their operand width.
  function automatic logic [63:0] opa_rom(input logic [31:0] k);
    return 64'(k) * 64'h0000_0000_0101_0101;
  endfunction

  function automatic logic [63:0] opb_rom(input logic [31:0] k);
    return 64'(k);
  endfunction

endpackage

// File: rtl/alu_nbits_core.sv
// Combinational WIDTH-bit ALU: AND/OR/ADD/XOR/NOR/SLT with optional inversion of b and carry-in.
module alu_nbits_core
  import alu_sweep_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             invert_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  assign b_eff = invert_i ? ~b_i : b_i;
  assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_i};

  always_comb begin
    res_o = '0;
    c_o   = 1'b0;
    case (op_i)
      OP_AND: res_o = a_i & b_eff;
      OP_OR:  res_o = a_i | b_eff;
      OP_ADD: begin
        res_o = sum[WIDTH-1:0];
        c_o   = sum[WIDTH];
      end
      OP_XOR: res_o = a_i ^ b_eff;
      OP_NOR: res_o = ~(a_i | b_eff);
      OP_SLT: begin
        res_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
        c_o   = sum[WIDTH];
      end
      default: res_o = '0;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/alu_sweep_pipe.sv
// Sweeps operand ROM pairs through a registered ALU with OUT_STAGES output registers and a signature.
// Define ALU_SWEEP_OVF_EN to add the sticky signed-overflow output ovf_o.
module alu_sweep_pipe
  import alu_sweep_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 3,
  parameter int CNT_W      = 8,
  parameter int OUT_STAGES = 1
) (
  input  logic              clk_i,
  input  logic              async_reset_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic              invert_i,
  input  logic              c_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] b_base_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              res_valid_o,
  output logic [WIDTH-1:0]  res_o,
  output logic              c_o,
  output logic              zeroflag_o,
  output logic [WIDTH-1:0]  signature_o,
`ifdef ALU_SWEEP_OVF_EN
  output logic              ovf_o,
`endif
  output logic [CNT_W-1:0]  zero_cnt_o
);

  localparam int LAST = OUT_STAGES - 1;

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [CNT_W-1:0]  vcnt_q, vcnt_d;
  logic [2:0]        op_q, op_d;
  logic              inv_q, inv_d, cin_q, cin_d;
  logic              start_ok, issue, pipe_busy;

  logic [WIDTH-1:0]  a_in_q, b_in_q;
  logic              in_v_q;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c, alu_z;
  logic [OUT_STAGES-1:0] stage_v;

  logic [WIDTH-1:0]  sig_q;
  logic [CNT_W-1:0]  zcnt_q;
  logic              last_load, last_z;
  logic [WIDTH-1:0]  last_res;

  // start is honoured only when no sweep is in flight.
  assign start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign issue     = (state_q == ST_RUN);
  assign pipe_busy = in_v_q || (|stage_v);

  always_comb begin
    state_d  = state_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    vcnt_d   = vcnt_q;
    op_d     = op_q;
    inv_d    = inv_q;
    cin_d    = cin_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          op_d     = op_i;
          inv_d    = invert_i;
          cin_d    = c_i;
          vcnt_d   = count_i;
          a_addr_d = a_base_i;
          b_addr_d = b_base_i;
          state_d  = (count_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        a_addr_d = a_addr_q + ADDR_W'(1);
        b_addr_d = b_addr_q + ADDR_W'(1);
        vcnt_d   = vcnt_q - CNT_W'(1);
        if (vcnt_q == CNT_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_busy) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i) begin
      state_q  <= ST_IDLE;
      a_addr_q <= '0;
      b_addr_q <= '0;
      vcnt_q   <= '0;
      op_q     <= '0;
      inv_q    <= 1'b0;
      cin_q    <= 1'b0;
      in_v_q   <= 1'b0;
      a_in_q   <= '0;
      b_in_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      vcnt_q   <= vcnt_d;
      op_q     <= op_d;
      inv_q    <= inv_d;
      cin_q    <= cin_d;
      in_v_q   <= issue;
      if (issue) begin
        a_in_q <= WIDTH'(opa_rom(32'(a_addr_q)));
        b_in_q <= WIDTH'(opb_rom(32'(b_addr_q)));
      end
    end
  end

  alu_nbits_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_in_q),
    .b_i      (b_in_q),
    .c_i      (cin_q),
    .invert_i (inv_q),
    .op_i     (op_q),
    .res_o    (alu_res),
    .c_o      (alu_c),
    .zero_o   (alu_z)
  );

  // Stages load only on valid data, so the last stage holds its result between strobes.
  genvar gi;
  for (gi = 0; gi < OUT_STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] res_src, res_q;
    logic             c_src, c_q, z_src, z_q, v_src, v_q;
    if (gi == 0) begin : g_head
      assign res_src = alu_res;
      assign c_src   = alu_c;
      assign z_src   = alu_z;
      assign v_src   = in_v_q;
    end else begin : g_tail
      assign res_src = g_stage[gi-1].res_q;
      assign c_src   = g_stage[gi-1].c_q;
      assign z_src   = g_stage[gi-1].z_q;
      assign v_src   = g_stage[gi-1].v_q;
    end
    always_ff @(posedge clk_i or negedge async_reset_i) begin
      if (!async_reset_i) begin
        v_q   <= 1'b0;
        res_q <= '0;
        c_q   <= 1'b0;
        z_q   <= 1'b0;
      end else begin
        v_q <= v_src;
        if (v_src) begin
          res_q <= res_src;
          c_q   <= c_src;
          z_q   <= z_src;
        end
      end
    end
    assign stage_v[gi] = v_q;
  end

  assign last_load = g_stage[LAST].v_src;
  assign last_res  = g_stage[LAST].res_src;
  assign last_z    = g_stage[LAST].z_src;

  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i) begin
      sig_q  <= '0;
      zcnt_q <= '0;
    end else if (start_ok) begin
      sig_q  <= '0;
      zcnt_q <= '0;
    end else if (last_load) begin
      sig_q <= {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ last_res;
      if (last_z && (zcnt_q != '1)) zcnt_q <= zcnt_q + CNT_W'(1);
    end
  end

`ifdef ALU_SWEEP_OVF_EN
  logic                  b_sgn, ovf_raw, ovf_q;
  logic [OUT_STAGES-1:0] ovf_chain;

  assign b_sgn   = inv_q ? ~b_in_q[WIDTH-1] : b_in_q[WIDTH-1];
  assign ovf_raw = (op_q == OP_ADD) && (a_in_q[WIDTH-1] == b_sgn) &&
                   (alu_res[WIDTH-1] != a_in_q[WIDTH-1]);
  assign ovf_chain[0] = ovf_raw;

  for (gi = 1; gi < OUT_STAGES; gi++) begin : g_ovf
    logic oq;
    always_ff @(posedge clk_i or negedge async_reset_i) begin
      if (!async_reset_i)               oq <= 1'b0;
      else if (g_stage[gi-1].v_src)     oq <= ovf_chain[gi-1];
    end
    assign ovf_chain[gi] = oq;
  end

  // The sticky flag doubles as the final output stage for overflow.
  always_ff @(posedge clk_i or negedge async_reset_i) begin
    if (!async_reset_i)                        ovf_q <= 1'b0;
    else if (start_ok)                         ovf_q <= 1'b0;
    else if (last_load && ovf_chain[LAST])     ovf_q <= 1'b1;
  end

  assign ovf_o = ovf_q;
`endif

  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);
  assign res_valid_o = stage_v[LAST];
  assign res_o       = g_stage[LAST].res_q;
  assign c_o         = g_stage[LAST].c_q;
  assign zeroflag_o  = g_stage[LAST].z_q;
  assign signature_o = sig_q;
  assign zero_cnt_o  = zcnt_q;

endmodule

// File: tb/tb_alu_sweep_pipe.sv
// Directed bench for alu_sweep_pipe (WIDTH=32, ADDR_W=3, CNT_W=8, OUT_STAGES=1) with hand-computed results.
module tb_alu_sweep_pipe;

  localparam logic [2:0] T_AND = 3'b000;
  localparam logic [2:0] T_OR  = 3'b001;
  localparam logic [2:0] T_ADD = 3'b010;
  localparam logic [2:0] T_XOR = 3'b011;
  localparam logic [2:0] T_NOR = 3'b100;
  localparam logic [2:0] T_SLT = 3'b101;

  logic        clk;
  logic        async_reset_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic        invert_i;
  logic        c_i;
  logic [2:0]  a_base_i;
  logic [2:0]  b_base_i;
  logic [7:0]  count_i;
  logic        busy_o, done_o, res_valid_o, c_o, zeroflag_o;
  logic [31:0] res_o, signature_o;
  logic [7:0]  zero_cnt_o;
`ifdef ALU_SWEEP_OVF_EN
  logic        ovf_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] got_res [16];
  logic        got_c   [16];
  logic        got_z   [16];
  int          got_n, first_n, last_n, done_n, seen_v;

  alu_sweep_pipe #(
    .WIDTH(32), .ADDR_W(3), .CNT_W(8), .OUT_STAGES(1)
  ) dut (
    .clk_i         (clk),
    .async_reset_i (async_reset_i),
    .start_i       (start_i),
    .op_i          (op_i),
    .invert_i      (invert_i),
    .c_i           (c_i),
    .a_base_i      (a_base_i),
    .b_base_i      (b_base_i),
    .count_i       (count_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .res_valid_o   (res_valid_o),
    .res_o         (res_o),
    .c_o           (c_o),
    .zeroflag_o    (zeroflag_o),
    .signature_o   (signature_o),
`ifdef ALU_SWEEP_OVF_EN
    .ovf_o         (ovf_o),
`endif
    .zero_cnt_o    (zero_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one sweep and record every result until done_o (bounded).
  task automatic run_sweep(input logic [2:0] op, input logic inv, input logic cin,
                           input logic [2:0] ab, input logic [2:0] bb, input logic [7:0] cnt);
    @(negedge clk);
    op_i = op; invert_i = inv; c_i = cin; a_base_i = ab; b_base_i = bb; count_i = cnt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    got_n = 0; first_n = -1; last_n = -1; done_n = -1;
    for (int n = 0; n < 60; n++) begin
      if (res_valid_o) begin
        if (got_n < 16) begin
          got_res[got_n] = res_o;
          got_c[got_n]   = c_o;
          got_z[got_n]   = zeroflag_o;
        end
        if (first_n < 0) first_n = n;
        last_n = n;
        got_n++;
      end
      if (done_o) begin
        done_n = n;
        break;
      end
      @(negedge clk);
    end
    chk("done_within_bound", 64'(done_n >= 0), 64'd1);
    $display("sweep op=%0d inv=%0d c=%0d a_base=%0d b_base=%0d count=%0d: %0d results, first at %0d, done at %0d",
             op, inv, cin, ab, bb, cnt, got_n, first_n, done_n);
  endtask

  initial begin
    async_reset_i = 1'b0;
    start_i = 1'b0; op_i = '0; invert_i = 1'b0; c_i = 1'b0;
    a_base_i = '0; b_base_i = '0; count_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_res", 64'(res_o), 64'h0);
    chk("rst_flags", 64'({res_valid_o, busy_o, done_o, c_o, zeroflag_o}), 64'h0);
    chk("rst_sig", 64'(signature_o), 64'h0);
    chk("rst_zcnt", 64'(zero_cnt_o), 64'h0);
    async_reset_i = 1'b1;

    // ADD 0x02020202 + 3
    run_sweep(T_ADD, 1'b0, 1'b0, 3'd2, 3'd3, 8'd1);
    chk("add_n", 64'(got_n), 64'd1);
    chk("add_latency", 64'(first_n), 64'd2);
    chk("add_res", 64'(got_res[0]), 64'h02020205);
    chk("add_cz", 64'({got_c[0], got_z[0]}), 64'h0);
    chk("add_sig", 64'(signature_o), 64'h02020205);
    chk("add_hold_res", 64'(res_o), 64'h02020205);
    chk("add_done_busy", 64'({done_o, busy_o}), 64'b10);

    // SUB 0 - 0
    run_sweep(T_ADD, 1'b1, 1'b1, 3'd0, 3'd0, 8'd1);
    chk("sub_res", 64'(got_res[0]), 64'h0);
    chk("sub_cz", 64'({got_c[0], got_z[0]}), 64'b11);
    chk("sub_zcnt", 64'(zero_cnt_o), 64'd1);
    chk("sub_sig", 64'(signature_o), 64'h0);

    // XOR across the address wrap 6,7,0,1
    run_sweep(T_XOR, 1'b0, 1'b0, 3'd6, 3'd6, 8'd4);
    chk("xor_n", 64'(got_n), 64'd4);
    chk("xor_latency", 64'(first_n), 64'd2);
    chk("xor_back_to_back", 64'(last_n - first_n), 64'd3);
    chk("xor_res0", 64'(got_res[0]), 64'h06060600);
    chk("xor_res1", 64'(got_res[1]), 64'h07070700);
    chk("xor_res2", 64'(got_res[2]), 64'h0);
    chk("xor_res3", 64'(got_res[3]), 64'h01010100);
    chk("xor_zcnt", 64'(zero_cnt_o), 64'd1);
    chk("xor_sig", 64'(signature_o), 64'h2D2D2D00);

    // count = 0 goes straight to DONE and clears the signature
    run_sweep(T_AND, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0);
    chk("zero_done_at", 64'(done_n), 64'd0);
    chk("zero_no_results", 64'(got_n), 64'd0);
    chk("zero_sig", 64'(signature_o), 64'h0);
    chk("zero_zcnt", 64'(zero_cnt_o), 64'h0);

    // SLT: 0 < 1 signed, and 0x01010101 < 2 is false
    run_sweep(T_SLT, 1'b1, 1'b1, 3'd0, 3'd1, 8'd1);
    chk("slt_true_res", 64'(got_res[0]), 64'd1);
    chk("slt_true_c", 64'(got_c[0]), 64'd0);
    run_sweep(T_SLT, 1'b1, 1'b1, 3'd1, 3'd2, 8'd1);
    chk("slt_false_res", 64'(got_res[0]), 64'd0);
    chk("slt_false_cz", 64'({got_c[0], got_z[0]}), 64'b11);

    // NOR over two vectors
    run_sweep(T_NOR, 1'b0, 1'b0, 3'd0, 3'd0, 8'd2);
    chk("nor_res0", 64'(got_res[0]), 64'hFFFFFFFF);
    chk("nor_res1", 64'(got_res[1]), 64'hFEFEFEFE);
    chk("nor_sig", 64'(signature_o), 64'h01010101);

    // unused opcode, OR, and ADD with carry out
    run_sweep(3'b110, 1'b0, 1'b0, 3'd5, 3'd5, 8'd1);
    chk("op6_res", 64'(got_res[0]), 64'h0);
    chk("op6_zcnt", 64'(zero_cnt_o), 64'd1);
    run_sweep(T_OR, 1'b0, 1'b0, 3'd4, 3'd3, 8'd1);
    chk("or_res", 64'(got_res[0]), 64'h04040407);
    run_sweep(T_ADD, 1'b1, 1'b0, 3'd7, 3'd0, 8'd1);
    chk("addc_res", 64'(got_res[0]), 64'h07070706);
    chk("addc_c", 64'(got_c[0]), 64'd1);

    // Reset in the middle of an 8-vector sweep
    @(negedge clk);
    op_i = T_ADD; invert_i = 1'b0; c_i = 1'b0; a_base_i = 3'd0; b_base_i = 3'd0; count_i = 8'd8;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    #2 async_reset_i = 1'b0;
    #1;
    chk("midrst_res", 64'(res_o), 64'h0);
    chk("midrst_flags", 64'({res_valid_o, busy_o, done_o, c_o, zeroflag_o}), 64'h0);
    chk("midrst_sig", 64'(signature_o), 64'h0);
    chk("midrst_zcnt", 64'(zero_cnt_o), 64'h0);
    $display("reset asserted mid-sweep");
    repeat (2) @(negedge clk);
    async_reset_i = 1'b1;
    seen_v = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (res_valid_o || busy_o) seen_v++;
    end
    chk("no_activity_after_rst", 64'(seen_v), 64'd0);
    run_sweep(T_AND, 1'b0, 1'b0, 3'd3, 3'd1, 8'd1);
    chk("post_rst_res", 64'(got_res[0]), 64'h1);
    chk("post_rst_latency", 64'(first_n), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
